// File: rtl/ram_pkg.sv
// Shared types and address-map constants for the SR-1 main memory and its I/O window.
package ram_pkg;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] byte_t;

  localparam addr_t       IO_BASE     = 15'h7FF0;
  localparam logic [3:0]  IO_SW1      = 4'h0;
  localparam logic [3:0]  IO_SW2      = 4'h1;
  localparam logic [3:0]  IO_BTN1     = 4'h2;
  localparam logic [3:0]  IO_PRESCALE = 4'h3;
  localparam int unsigned RAM_DEPTH   = 32752;

  // Which registered source currently drives mem_do.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_IO
  } rd_src_e;

  function automatic logic is_io(input addr_t a);
    return a >= IO_BASE;
  endfunction
endpackage

// File: rtl/ram_mmio_if.sv
// CPU-side load/store bus of the main memory.
interface ram_mmio_if;
  import ram_pkg::*;

  addr_t address;
  logic  read;
  logic  write;
  byte_t mem_di;
  byte_t mem_do;

  modport master (output address, output read, output write, output mem_di, input mem_do);
  modport slave  (input address, input read, input write, input mem_di, output mem_do);
endinterface

// File: rtl/ram_mmio_io_sync.sv
// Two-flop synchronizer for asynchronous board inputs, cleared by reset.
module io_sync #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ram_mmio.sv
// Byte-wide SR-1 main memory with a 16-byte memory-mapped I/O window at the top.
module ram_mmio
  import ram_pkg::*;
(
  input  logic       mem_clk,
  input  logic       mem_reset,
  ram_mmio_if.slave  bus,
  input  byte_t      sw1,
  input  byte_t      sw2,
  input  byte_t      btn1,
  output byte_t      mm_prescale
);
  byte_t      ram [RAM_DEPTH];
  byte_t      ram_q;
  byte_t      io_q;
  byte_t      io_rd;
  byte_t      sw1_s;
  byte_t      sw2_s;
  byte_t      btn1_s;
  rd_src_e    rd_src;
  logic       in_io;
  logic [3:0] io_off;

  io_sync #(.W(DATA_W)) u_sync_sw1  (.clk(mem_clk), .rst_n(mem_reset), .d(sw1),  .q(sw1_s));
  io_sync #(.W(DATA_W)) u_sync_sw2  (.clk(mem_clk), .rst_n(mem_reset), .d(sw2),  .q(sw2_s));
  io_sync #(.W(DATA_W)) u_sync_btn1 (.clk(mem_clk), .rst_n(mem_reset), .d(btn1), .q(btn1_s));

  assign in_io  = is_io(bus.address);
  assign io_off = bus.address[3:0];

  always_comb begin
    io_rd = '0;
    case (io_off)
      IO_SW1:      io_rd = sw1_s;
      IO_SW2:      io_rd = sw2_s;
      IO_BTN1:     io_rd = btn1_s;
      IO_PRESCALE: io_rd = mm_prescale;
      default:     io_rd = '0;
    endcase
  end

  // Array kept reset-free with a plain synchronous read so it maps onto block RAM;
  // the old word is read in the same edge a write lands, giving read-first.
  always_ff @(posedge mem_clk) begin
    if (bus.write && !in_io)
      ram[bus.address] <= bus.mem_di;
    if (bus.read && !in_io)
      ram_q <= ram[bus.address];
  end

  always_ff @(posedge mem_clk or negedge mem_reset) begin
    if (!mem_reset) begin
      rd_src      <= SRC_NONE;
      io_q        <= '0;
      mm_prescale <= '0;
    end else begin
      if (bus.read) begin
        rd_src <= in_io ? SRC_IO : SRC_RAM;
        if (in_io)
          io_q <= io_rd;
      end
      if (bus.write && in_io && io_off == IO_PRESCALE)
        mm_prescale <= bus.mem_di;
    end
  end

  // mem_do selects between registered sources only; SRC_NONE gives the
  // asynchronous zero on reset without putting a reset on the RAM output.
  always_comb begin
    bus.mem_do = '0;
    case (rd_src)
      SRC_RAM: bus.mem_do = ram_q;
      SRC_IO:  bus.mem_do = io_q;
      default: bus.mem_do = '0;
    endcase
  end
endmodule

// File: tb/tb_ram_mmio.sv
// Self-checking bench for ram_mmio: directed address-map cases plus randomized traffic against a reference model.
module tb_ram_mmio;
  import ram_pkg::*;

  logic  mem_clk   = 1'b0;
  logic  mem_reset = 1'b0;
  byte_t sw1  = '0;
  byte_t sw2  = '0;
  byte_t btn1 = '0;
  byte_t mm_prescale;

  ram_mmio_if bus ();

  ram_mmio dut (
    .mem_clk     (mem_clk),
    .mem_reset   (mem_reset),
    .bus         (bus.slave),
    .sw1         (sw1),
    .sw2         (sw2),
    .btn1        (btn1),
    .mm_prescale (mm_prescale)
  );

  always #5 mem_clk = ~mem_clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: sparse byte memory, prescale value, and board inputs
  // as they stood before each of the last two clock edges.
  byte_t       mem_m [int];
  byte_t       pre_m;
  logic [23:0] in_prev1;
  logic [23:0] in_prev2;
  byte_t       exp_do;
  bit          exp_known;

  task automatic check(input string tag, input byte_t got, input byte_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input string tag, input addr_t a, input logic rd, input logic wr, input byte_t d);
    logic [23:0] vis;
    addr_t       off;
    vis      = in_prev2;
    in_prev2 = in_prev1;
    in_prev1 = {sw1, sw2, btn1};
    if (rd) begin
      if (a < IO_BASE) begin
        exp_known = mem_m.exists(int'(a));
        if (exp_known) exp_do = mem_m[int'(a)];
      end else begin
        off       = a - IO_BASE;
        exp_known = 1'b1;
        case (off)
          15'd0:   exp_do = vis[23:16];
          15'd1:   exp_do = vis[15:8];
          15'd2:   exp_do = vis[7:0];
          15'd3:   exp_do = pre_m;
          default: exp_do = 8'h00;
        endcase
      end
    end
    if (wr) begin
      if (a < IO_BASE)            mem_m[int'(a)] = d;
      else if (a == IO_BASE + 3)  pre_m = d;
    end
    bus.address = a;
    bus.read    = rd;
    bus.write   = wr;
    bus.mem_di  = d;
    @(posedge mem_clk);
    #1;
    if (exp_known) check({tag, ".mem_do"}, bus.mem_do, exp_do);
    check({tag, ".prescale"}, mm_prescale, pre_m);
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    mem_reset = 1'b0;
    #2;
    check({tag, ".mem_do"}, bus.mem_do, 8'h00);
    check({tag, ".prescale"}, mm_prescale, 8'h00);
    mem_reset = 1'b1;
    pre_m     = 8'h00;
    exp_do    = 8'h00;
    exp_known = 1'b1;
    in_prev1  = '0;
    in_prev2  = '0;
    #1;
  endtask

  addr_t pool [8];

  initial begin
    bus.address = '0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.mem_di  = '0;
    pool = '{15'h0000, 15'h0001, 15'h0002, 15'h0100, 15'h1234, 15'h3FFF, 15'h7FEE, 15'h7FEF};

    do_reset("reset0");

    sw1 = 8'd26; sw2 = 8'd134; btn1 = 8'd247;
    step("idle", '0, 1'b0, 1'b0, '0);
    step("idle", '0, 1'b0, 1'b0, '0);
    step("rd_sw1",  15'h7FF0, 1'b1, 1'b0, '0);
    step("rd_sw2",  15'h7FF1, 1'b1, 1'b0, '0);
    step("rd_btn1", 15'h7FF2, 1'b1, 1'b0, '0);
    step("hold",    '0, 1'b0, 1'b0, '0);

    // Synchronizer latency: change becomes visible on the third read only.
    sw1 = 8'h40;
    step("sync_e0", 15'h7FF0, 1'b1, 1'b0, '0);
    step("sync_e1", 15'h7FF0, 1'b1, 1'b0, '0);
    step("sync_e2", 15'h7FF0, 1'b1, 1'b0, '0);
    sw1 = 8'd26;
    step("idle", '0, 1'b0, 1'b0, '0);
    step("idle", '0, 1'b0, 1'b0, '0);

    step("wr_lo",   15'h0000, 1'b0, 1'b1, 8'h5A);
    step("wr_hi",   15'h7FEF, 1'b0, 1'b1, 8'hA5);
    step("rd_lo",   15'h0000, 1'b1, 1'b0, '0);
    step("rd_hi",   15'h7FEF, 1'b1, 1'b0, '0);
    step("rd_rsv",  15'h7FF4, 1'b1, 1'b0, '0);
    step("rd_top",  15'h7FFF, 1'b1, 1'b0, '0);

    step("wr_pre",  15'h7FF3, 1'b0, 1'b1, 8'h3C);
    step("rd_pre",  15'h7FF3, 1'b1, 1'b0, '0);
    step("wr_ro",   15'h7FF0, 1'b0, 1'b1, 8'h99);
    step("rd_ro",   15'h7FF0, 1'b1, 1'b0, '0);
    step("wr_rsv",  15'h7FF8, 1'b0, 1'b1, 8'h77);
    step("rd_rsv2", 15'h7FF8, 1'b1, 1'b0, '0);

    step("wr_100",  15'h0100, 1'b0, 1'b1, 8'h11);
    step("rf_old",  15'h0100, 1'b1, 1'b1, 8'h22);
    step("rf_new",  15'h0100, 1'b1, 1'b0, '0);

    do_reset("reset_mid");
    step("rd_keep", 15'h0000, 1'b1, 1'b0, '0);

    for (int i = 0; i < 600; i++) begin
      addr_t a;
      logic  rd;
      logic  wr;
      if ($urandom_range(0, 7) == 0) begin
        sw1  = byte_t'($urandom);
        sw2  = byte_t'($urandom);
        btn1 = byte_t'($urandom);
      end
      if ($urandom_range(0, 3) == 0) a = IO_BASE + addr_t'($urandom_range(0, 15));
      else                          a = pool[$urandom_range(0, 7)];
      rd = ($urandom_range(0, 2) != 0);
      wr = ($urandom_range(0, 2) == 0);
      step("rand", a, rd, wr, byte_t'($urandom));
      if ($urandom_range(0, 149) == 0) do_reset("rand_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
